// File: rtl/word_pkg.sv
// Glyph code map shared by word_gen (producer) and glyph_scan_driver (consumer).
// Codes 0..15 are hex digits; the letters, symbols and blanks follow.
package word_pkg;

  typedef logic [4:0] glyph_t;

  localparam glyph_t GLYPH_H     = 5'd16;
  localparam glyph_t GLYPH_J     = 5'd17;
  localparam glyph_t GLYPH_U     = 5'd18;
  localparam glyph_t GLYPH_N     = 5'd19;
  localparam glyph_t GLYPH_R     = 5'd20;
  localparam glyph_t GLYPH_P     = 5'd21;
  localparam glyph_t GLYPH_L     = 5'd22;
  localparam glyph_t GLYPH_G     = 5'd23;
  localparam glyph_t GLYPH_Y     = 5'd24;
  localparam glyph_t GLYPH_T     = 5'd25;
  localparam glyph_t GLYPH_DASH  = 5'd26;
  localparam glyph_t GLYPH_UNDER = 5'd27;
  localparam glyph_t GLYPH_O     = 5'd28;
  localparam glyph_t GLYPH_C     = 5'd29;
  localparam glyph_t GLYPH_BLANK = 5'd30;
  localparam glyph_t GLYPH_END   = 5'd31;

  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/glyph_decode.sv
// Combinational glyph code to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
module glyph_decode
  import word_pkg::*;
(
  input  glyph_t     code_i,
  output logic [6:0] seg_o
);

  // Lookup of lit segments per glyph; a 0 bit lights the segment
  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      5'd0:        seg_o = 7'h40;
      5'd1:        seg_o = 7'h79;
      5'd2:        seg_o = 7'h24;
      5'd3:        seg_o = 7'h30;
      5'd4:        seg_o = 7'h19;
      5'd5:        seg_o = 7'h12;
      5'd6:        seg_o = 7'h02;
      5'd7:        seg_o = 7'h78;
      5'd8:        seg_o = 7'h00;
      5'd9:        seg_o = 7'h10;
      5'd10:       seg_o = 7'h08;
      5'd11:       seg_o = 7'h03;
      5'd12:       seg_o = 7'h46;
      5'd13:       seg_o = 7'h21;
      5'd14:       seg_o = 7'h06;
      5'd15:       seg_o = 7'h0E;
      GLYPH_H:     seg_o = 7'h09;
      GLYPH_J:     seg_o = 7'h61;
      GLYPH_U:     seg_o = 7'h41;
      GLYPH_N:     seg_o = 7'h2B;
      GLYPH_R:     seg_o = 7'h2F;
      GLYPH_P:     seg_o = 7'h0C;
      GLYPH_L:     seg_o = 7'h47;
      GLYPH_G:     seg_o = 7'h42;
      GLYPH_Y:     seg_o = 7'h11;
      GLYPH_T:     seg_o = 7'h07;
      GLYPH_DASH:  seg_o = 7'h3F;
      GLYPH_UNDER: seg_o = 7'h77;
      GLYPH_O:     seg_o = 7'h23;
      GLYPH_C:     seg_o = 7'h27;
      GLYPH_BLANK: seg_o = SEG_OFF;
      GLYPH_END:   seg_o = SEG_OFF;
      default:     seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/glyph_scan_driver.sv
// Four-digit common-anode scan driver: per-frame snapshot of glyph codes,
// per-slot dead-time, registered active-low segment/digit outputs.
module glyph_scan_driver
  import word_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] A,
  input  logic [4:0] B,
  input  logic [4:0] C,
  input  logic [4:0] D,
  input  logic [3:0] dp_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] dig,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             snap_pending_q, snap_pending_d;
  glyph_t [3:0]     shadow_q, shadow_d;
  logic [3:0]       shadow_dp_q, shadow_dp_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       dig_q, dig_d;
  logic             frame_done_q, frame_done_d;

  logic             terminal_s;
  logic             snap_s;
  logic             blank_s;
  logic [6:0]       dec_seg_s;

  assign terminal_s = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign snap_s     = enable & (snap_pending_q | (terminal_s & (idx_q == 2'd3)));
  assign blank_s    = (cnt_q < CNT_W'(BLANK_CYCLES));

  glyph_decode u_decode (
    .code_i (shadow_q[idx_q]),
    .seg_o  (dec_seg_s)
  );

  // Next-state: scan counter, frame snapshot and output pattern for the current slot
  always_comb begin
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    snap_pending_d = snap_pending_q;
    shadow_d       = shadow_q;
    shadow_dp_d    = shadow_dp_q;
    seg_d          = SEG_OFF;
    dp_d           = 1'b1;
    dig_d          = 4'hF;
    frame_done_d   = 1'b0;
    if (enable) begin
      if (terminal_s) begin
        cnt_d = '0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (snap_s) begin
        shadow_d       = {D, C, B, A};
        shadow_dp_d    = dp_in;
        snap_pending_d = 1'b0;
        frame_done_d   = 1'b1;
      end else begin
        frame_done_d   = 1'b0;
      end
      // Outputs reflect the pre-edge slot, so a wrap-time snapshot shows first in slot 0
      if (blank_s) begin
        dig_d = 4'hF;
      end else begin
        dig_d = ~(4'b0001 << idx_q);
        seg_d = dec_seg_s;
        dp_d  = ~shadow_dp_q[idx_q];
      end
    end else begin
      cnt_d          = '0;
      idx_d          = 2'd0;
      snap_pending_d = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q          <= '0;
      idx_q          <= 2'd0;
      snap_pending_q <= 1'b1;
      shadow_q       <= {4{GLYPH_BLANK}};
      shadow_dp_q    <= 4'h0;
      seg_q          <= SEG_OFF;
      dp_q           <= 1'b1;
      dig_q          <= 4'hF;
      frame_done_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      snap_pending_q <= snap_pending_d;
      shadow_q       <= shadow_d;
      shadow_dp_q    <= shadow_dp_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
      dig_q          <= dig_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig        = dig_q;
  assign frame_done = frame_done_q;

endmodule
